// File: rtl/arcino_multdiv_ctrl.sv
// arcino_multdiv_ctrl: one-deep request sequencer in front of arcino_multdiv_fast.
// Registers a mul/div request, runs the datapath, returns the result, caches DIV/REM.

package arcino_defines;
    typedef enum logic [1:0] {
        MD_OP_MULL = 2'd0,
        MD_OP_MULH = 2'd1,
        MD_OP_DIV  = 2'd2,
        MD_OP_REM  = 2'd3
    } md_op_e;
endpackage

module arcino_multdiv_ctrl
    import arcino_defines::*;
#(
    parameter bit RESULT_CACHE = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  md_op_e      req_op_i,
    input  logic [1:0]  req_signed_mode_i,
    input  logic [31:0] req_op_a_i,
    input  logic [31:0] req_op_b_i,
    input  logic        kill_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_result_o,
    output logic        md_mult_en_o,
    output logic        md_div_en_o,
    output md_op_e      md_operator_o,
    output logic [1:0]  md_signed_mode_o,
    output logic [31:0] md_op_a_o,
    output logic [31:0] md_op_b_o,
    input  logic        md_ready_i,
    input  logic [31:0] md_result_i,
    output logic        alu_sel_md_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MULT,
        S_DIV,
        S_DRAIN,
        S_RESP
    } state_e;

    state_e      state_q, state_d;
    md_op_e      op_q, op_d;
    logic [1:0]  mode_q, mode_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] res_q, res_d;

    logic        c_valid_q, c_valid_d;
    md_op_e      c_op_q, c_op_d;
    logic [1:0]  c_mode_q, c_mode_d;
    logic [31:0] c_a_q, c_a_d;
    logic [31:0] c_b_q, c_b_d;
    logic [31:0] c_res_q, c_res_d;

    logic req_is_div;
    logic op_is_div;
    logic accept;
    logic key_match;
    logic cache_hit;

    assign req_is_div = (req_op_i == MD_OP_DIV) || (req_op_i == MD_OP_REM);
    assign op_is_div  = (op_q == MD_OP_DIV) || (op_q == MD_OP_REM);
    assign accept     = (state_q == S_IDLE) && req_valid_i && !kill_i;

    // A DIV entry never answers a REM request because the op is part of the key.
    assign key_match = (req_op_i == c_op_q)
                    && (req_signed_mode_i == c_mode_q)
                    && (req_op_a_i == c_a_q)
                    && (req_op_b_i == c_b_q);
    assign cache_hit = RESULT_CACHE && c_valid_q && req_is_div && key_match;

    // State, request fields, result and cache registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            op_q      <= MD_OP_MULL;
            mode_q    <= 2'b00;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            c_valid_q <= 1'b0;
            c_op_q    <= MD_OP_MULL;
            c_mode_q  <= 2'b00;
            c_a_q     <= '0;
            c_b_q     <= '0;
            c_res_q   <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            mode_q    <= mode_d;
            a_q       <= a_d;
            b_q       <= b_d;
            res_q     <= res_d;
            c_valid_q <= c_valid_d;
            c_op_q    <= c_op_d;
            c_mode_q  <= c_mode_d;
            c_a_q     <= c_a_d;
            c_b_q     <= c_b_d;
            c_res_q   <= c_res_d;
        end
    end

    // Next state, request capture, result capture and cache fill.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        mode_d    = mode_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        c_valid_d = c_valid_q;
        c_op_d    = c_op_q;
        c_mode_d  = c_mode_q;
        c_a_d     = c_a_q;
        c_b_d     = c_b_q;
        c_res_d   = c_res_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d   = req_op_i;
                    mode_d = req_signed_mode_i;
                    a_d    = req_op_a_i;
                    b_d    = req_op_b_i;
                    if (cache_hit) begin
                        res_d   = c_res_q;
                        state_d = S_RESP;
                    end else if (req_is_div) begin
                        state_d = S_DIV;
                    end else begin
                        state_d = S_MULT;
                    end
                end
            end
            S_MULT: begin
                if (md_ready_i) begin
                    if (kill_i) begin
                        state_d = S_IDLE;
                    end else begin
                        res_d   = md_result_i;
                        state_d = S_RESP;
                    end
                end else if (kill_i) begin
                    state_d = S_DRAIN;
                end
            end
            S_DIV: begin
                if (md_ready_i) begin
                    if (kill_i) begin
                        state_d = S_IDLE;
                    end else begin
                        res_d   = md_result_i;
                        state_d = S_RESP;
                        if (RESULT_CACHE) begin
                            c_valid_d = 1'b1;
                            c_op_d    = op_q;
                            c_mode_d  = mode_q;
                            c_a_d     = a_q;
                            c_b_d     = b_q;
                            c_res_d   = md_result_i;
                        end
                    end
                end else if (kill_i) begin
                    state_d = S_DRAIN;
                end
            end
            // The datapath only advances with its enable high, so run it out.
            S_DRAIN: begin
                if (md_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            S_RESP: begin
                if (kill_i || resp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake and datapath enables decoded from the state.
    always_comb begin
        req_ready_o  = 1'b0;
        md_mult_en_o = 1'b0;
        md_div_en_o  = 1'b0;
        resp_valid_o = 1'b0;
        unique case (state_q)
            S_IDLE:  req_ready_o  = 1'b1;
            S_MULT:  md_mult_en_o = 1'b1;
            S_DIV:   md_div_en_o  = 1'b1;
            S_DRAIN: begin
                md_div_en_o  = op_is_div;
                md_mult_en_o = !op_is_div;
            end
            S_RESP:  resp_valid_o = 1'b1;
            default: ;
        endcase
    end

    assign alu_sel_md_o     = md_div_en_o;
    assign md_operator_o    = op_q;
    assign md_signed_mode_o = mode_q;
    assign md_op_a_o        = a_q;
    assign md_op_b_o        = b_q;
    assign resp_result_o    = res_q;

endmodule

// File: tb/tb_arcino_multdiv_ctrl.sv
// tb_arcino_multdiv_ctrl: vector table, kill/reset sequences and random traffic
// against a cycle-count datapath model and an arithmetic reference.

module tb_arcino_multdiv_ctrl;
    import arcino_defines::*;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_valid_i;
    logic        req_ready_o;
    md_op_e      req_op_i;
    logic [1:0]  req_signed_mode_i;
    logic [31:0] req_op_a_i;
    logic [31:0] req_op_b_i;
    logic        kill_i;
    logic        resp_valid_o;
    logic        resp_ready_i;
    logic [31:0] resp_result_o;
    logic        md_mult_en_o;
    logic        md_div_en_o;
    md_op_e      md_operator_o;
    logic [1:0]  md_signed_mode_o;
    logic [31:0] md_op_a_o;
    logic [31:0] md_op_b_o;
    logic        md_ready_i;
    logic [31:0] md_result_i;
    logic        alu_sel_md_o;

    always #5 clk_i = ~clk_i;

    arcino_multdiv_ctrl #(.RESULT_CACHE(1'b1)) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .req_valid_i       (req_valid_i),
        .req_ready_o       (req_ready_o),
        .req_op_i          (req_op_i),
        .req_signed_mode_i (req_signed_mode_i),
        .req_op_a_i        (req_op_a_i),
        .req_op_b_i        (req_op_b_i),
        .kill_i            (kill_i),
        .resp_valid_o      (resp_valid_o),
        .resp_ready_i      (resp_ready_i),
        .resp_result_o     (resp_result_o),
        .md_mult_en_o      (md_mult_en_o),
        .md_div_en_o       (md_div_en_o),
        .md_operator_o     (md_operator_o),
        .md_signed_mode_o  (md_signed_mode_o),
        .md_op_a_o         (md_op_a_o),
        .md_op_b_o         (md_op_b_o),
        .md_ready_i        (md_ready_i),
        .md_result_i       (md_result_i),
        .alu_sel_md_o      (alu_sel_md_o)
    );

    // Architectural result of an op, from 64-bit integer arithmetic.
    function automatic logic [31:0] ref_fn(input md_op_e op, input logic [1:0] m,
                                           input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p;
        sa = m[0] ? longint'($signed(a)) : longint'({32'h0, a});
        sb = m[1] ? longint'($signed(b)) : longint'({32'h0, b});
        p = sa * sb;
        case (op)
            MD_OP_MULL: return p[31:0];
            MD_OP_MULH: return p[63:32];
            MD_OP_DIV: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                p = sa / sb;
                return p[31:0];
            end
            default: begin
                if (b == 32'h0) return a;
                p = sa % sb;
                return p[31:0];
            end
        endcase
    endfunction

    // Number of enable-high cycles the datapath needs for an op.
    function automatic int need_cycles(input md_op_e op, input logic [31:0] b);
        if (op == MD_OP_MULL) return 3;
        if (op == MD_OP_MULH) return 4;
        if (b == 32'h0) return 2;
        return 37;
    endfunction

    // Datapath stand-in: ready on the last enable-high cycle of the op.
    int   dp_cnt;
    logic dp_en;
    assign dp_en = md_mult_en_o | md_div_en_o;
    assign md_ready_i = dp_en && (dp_cnt == need_cycles(md_operator_o, md_op_b_o) - 1);
    assign md_result_i = md_ready_i
        ? ref_fn(md_operator_o, md_signed_mode_o, md_op_a_o, md_op_b_o)
        : 32'hDEAD_BEEF;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) dp_cnt <= 0;
        else if (md_ready_i) dp_cnt <= 0;
        else if (dp_en) dp_cnt <= dp_cnt + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " ready/valid/en"},
              {28'h0, req_ready_o, resp_valid_o, md_mult_en_o, md_div_en_o}, 32'h8);
        check({tag, " alu_sel"}, {31'h0, alu_sel_md_o}, 32'h0);
        check({tag, " result"}, resp_result_o, 32'h0);
        check({tag, " md_a|md_b"}, md_op_a_o | md_op_b_o, 32'h0);
        check({tag, " md_op/mode"}, {28'h0, md_operator_o, md_signed_mode_o}, 32'h0);
    endtask

    // One request; counts cycles from the accept edge (cycle 0).
    task automatic do_txn(input md_op_e op, input logic [1:0] mode,
                          input logic [31:0] a, input logic [31:0] b,
                          input int kill_at, input int kill_at2,
                          input int hold, input bit kill_resp,
                          output int lat, output logic [31:0] res,
                          output int en_cnt, output int rdy_at, output int bad);
        int c;
        int w;
        lat = 0;
        res = '0;
        en_cnt = 0;
        rdy_at = 0;
        bad = 0;
        w = 0;
        while (!req_ready_o && w < 200) begin
            tick();
            w++;
        end
        if (!req_ready_o) begin
            bad++;
            return;
        end
        req_valid_i = 1'b1;
        req_op_i = op;
        req_signed_mode_i = mode;
        req_op_a_i = a;
        req_op_b_i = b;
        tick();
        req_valid_i = 1'b0;
        req_op_a_i = $urandom;
        req_op_b_i = $urandom;
        c = 1;
        while (c < 120) begin
            if (md_mult_en_o && md_div_en_o) bad++;
            if (alu_sel_md_o !== md_div_en_o) bad++;
            if (md_operator_o !== op || md_signed_mode_o !== mode) bad++;
            if (md_op_a_o !== a || md_op_b_o !== b) bad++;
            if (md_mult_en_o || md_div_en_o) en_cnt++;
            if (resp_valid_o) begin
                lat = c;
                res = resp_result_o;
                break;
            end
            if (req_ready_o) begin
                rdy_at = c;
                break;
            end
            kill_i = (c == kill_at) || (c == kill_at2);
            tick();
            c++;
        end
        kill_i = 1'b0;
        if (lat > 0) begin
            if (kill_resp) begin
                kill_i = 1'b1;
                tick();
                kill_i = 1'b0;
                if (resp_valid_o || !req_ready_o) bad++;
            end else begin
                for (int h = 0; h < hold; h++) begin
                    tick();
                    if (!resp_valid_o || resp_result_o !== res || req_ready_o) bad++;
                end
                resp_ready_i = 1'b1;
                tick();
                resp_ready_i = 1'b0;
                if (!req_ready_o || resp_valid_o) bad++;
            end
        end
    endtask

    typedef struct {
        md_op_e      op;
        logic [1:0]  mode;
        logic [31:0] a;
        logic [31:0] b;
        int          hold;
        logic [31:0] res;
        int          lat;
        int          en;
    } vec_t;

    vec_t vt[14];

    // Reference DIV/REM cache: last completed, un-killed division.
    logic        rc_valid;
    md_op_e      rc_op;
    logic [1:0]  rc_mode;
    logic [31:0] rc_a;
    logic [31:0] rc_b;

    initial begin : main
        int lat, en, rdy, bad, ka, hd, need;
        logic [31:0] res, a, b;
        md_op_e op;
        logic [1:0] m;
        bit hit, killed;

        vt[0]  = '{MD_OP_MULL, 2'b00, 32'h0001_0003, 32'h0002_0005, 0, 32'h000B_000F, 4, 3};
        vt[1]  = '{MD_OP_MULH, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'h0000_0000, 5, 4};
        vt[2]  = '{MD_OP_MULH, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFE, 5, 4};
        vt[3]  = '{MD_OP_DIV,  2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 0, 32'hFFFF_FFFD, 38, 37};
        vt[4]  = '{MD_OP_DIV,  2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 5, 32'hFFFF_FFFD, 1, 0};
        vt[5]  = '{MD_OP_REM,  2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 0, 32'hFFFF_FFFF, 38, 37};
        vt[6]  = '{MD_OP_REM,  2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 1, 32'hFFFF_FFFF, 1, 0};
        vt[7]  = '{MD_OP_DIV,  2'b00, 32'hFFFF_FFF9, 32'h0000_0002, 0, 32'h7FFF_FFFC, 38, 37};
        vt[8]  = '{MD_OP_DIV,  2'b00, 32'h0000_0005, 32'h0000_0000, 0, 32'hFFFF_FFFF, 3, 2};
        vt[9]  = '{MD_OP_REM,  2'b00, 32'h0000_0005, 32'h0000_0000, 0, 32'h0000_0005, 3, 2};
        vt[10] = '{MD_OP_MULL, 2'b00, 32'h0000_0003, 32'h0000_0004, 0, 32'h0000_000C, 4, 3};
        vt[11] = '{MD_OP_REM,  2'b00, 32'h0000_0005, 32'h0000_0000, 0, 32'h0000_0005, 1, 0};
        vt[12] = '{MD_OP_MULH, 2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 0, 32'hFFFF_FFFF, 5, 4};
        vt[13] = '{MD_OP_DIV,  2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000, 38, 37};

        req_valid_i = 1'b0;
        req_op_i = MD_OP_MULL;
        req_signed_mode_i = 2'b00;
        req_op_a_i = '0;
        req_op_b_i = '0;
        kill_i = 1'b0;
        resp_ready_i = 1'b0;

        tick();
        tick();
        check_idle_outputs("reset");
        rst_ni = 1'b1;
        tick();
        check_idle_outputs("post-reset");

        foreach (vt[i]) begin
            do_txn(vt[i].op, vt[i].mode, vt[i].a, vt[i].b, 0, 0, vt[i].hold, 1'b0,
                   lat, res, en, rdy, bad);
            check($sformatf("vec%0d result", i), res, vt[i].res);
            check($sformatf("vec%0d latency", i), lat, vt[i].lat);
            check($sformatf("vec%0d enables", i), en, vt[i].en);
            check($sformatf("vec%0d protocol", i), bad, 0);
        end

        // Kill at cycle 10 of a divide, plus a second kill while draining.
        do_txn(MD_OP_DIV, 2'b00, 32'd100, 32'd7, 10, 20, 0, 1'b0, lat, res, en, rdy, bad);
        check("kill div no resp", lat, 0);
        check("kill div enables", en, 37);
        check("kill div ready at", rdy, 38);
        check("kill div protocol", bad, 0);
        do_txn(MD_OP_MULL, 2'b00, 32'd3, 32'd4, 0, 0, 0, 1'b0, lat, res, en, rdy, bad);
        check("after drain mull", res, 32'h0000_000C);
        check("after drain lat", lat, 4);
        do_txn(MD_OP_DIV, 2'b00, 32'd100, 32'd7, 0, 0, 0, 1'b0, lat, res, en, rdy, bad);
        check("killed div not cached", lat, 38);
        check("div 100/7", res, 32'd14);

        // Kill in the same cycle as md_ready.
        do_txn(MD_OP_MULL, 2'b00, 32'd3, 32'd4, 3, 0, 0, 1'b0, lat, res, en, rdy, bad);
        check("kill@ready no resp", lat, 0);
        check("kill@ready ready at", rdy, 4);
        check("kill@ready enables", en, 3);

        // Kill while the response waits.
        do_txn(MD_OP_MULH, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 1'b1,
               lat, res, en, rdy, bad);
        check("kill resp lat", lat, 5);
        check("kill resp dropped", bad, 0);

        // Kill with a request in IDLE must block the accept.
        req_valid_i = 1'b1;
        req_op_i = MD_OP_MULL;
        kill_i = 1'b1;
        tick();
        req_valid_i = 1'b0;
        kill_i = 1'b0;
        check("kill idle no accept",
              {29'h0, req_ready_o, md_mult_en_o, resp_valid_o}, 32'h4);

        // Cache hit on 100/7, then reset mid-divide clears the cache.
        do_txn(MD_OP_DIV, 2'b00, 32'd100, 32'd7, 0, 0, 0, 1'b0, lat, res, en, rdy, bad);
        check("100/7 hit lat", lat, 1);
        req_valid_i = 1'b1;
        req_op_i = MD_OP_DIV;
        req_signed_mode_i = 2'b00;
        req_op_a_i = 32'd9;
        req_op_b_i = 32'd3;
        tick();
        req_valid_i = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("mid div enable", {31'h0, md_div_en_o}, 32'h1);
        rst_ni = 1'b0;
        #1;
        check_idle_outputs("mid-op reset");
        tick();
        rst_ni = 1'b1;
        tick();
        do_txn(MD_OP_DIV, 2'b00, 32'd100, 32'd7, 0, 0, 0, 1'b0, lat, res, en, rdy, bad);
        check("reset clears cache", lat, 38);
        rc_valid = 1'b1;
        rc_op = MD_OP_DIV;
        rc_mode = 2'b00;
        rc_a = 32'd100;
        rc_b = 32'd7;

        for (int n = 0; n < 150; n++) begin
            if (rc_valid && $urandom_range(0, 3) == 0) begin
                op = $urandom_range(0, 1) ? rc_op
                   : (rc_op == MD_OP_DIV ? MD_OP_REM : MD_OP_DIV);
                m = rc_mode;
                a = rc_a;
                b = rc_b;
            end else begin
                op = md_op_e'($urandom_range(0, 3));
                m = 2'($urandom_range(0, 3));
                case ($urandom_range(0, 5))
                    0: a = 32'h8000_0000;
                    1: a = 32'hFFFF_FFFF;
                    2: a = 32'd7;
                    default: a = $urandom;
                endcase
                case ($urandom_range(0, 5))
                    0: b = 32'h0;
                    1: b = 32'hFFFF_FFFF;
                    2: b = 32'd3;
                    default: b = $urandom;
                endcase
            end
            hit = rc_valid && (op == MD_OP_DIV || op == MD_OP_REM)
               && op == rc_op && m == rc_mode && a == rc_a && b == rc_b;
            need = hit ? 0 : need_cycles(op, b);
            ka = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 40) : 0;
            killed = !hit && ka >= 1 && ka <= need;
            hd = $urandom_range(0, 3);
            do_txn(op, m, a, b, ka, 0, hd, 1'b0, lat, res, en, rdy, bad);
            check($sformatf("rnd%0d enables", n), en, need);
            check($sformatf("rnd%0d protocol", n), bad, 0);
            if (killed) begin
                check($sformatf("rnd%0d killed resp", n), lat, 0);
                check($sformatf("rnd%0d killed ready", n), rdy, need + 1);
            end else begin
                check($sformatf("rnd%0d latency", n), lat, need + 1);
                check($sformatf("rnd%0d result", n), res, ref_fn(op, m, a, b));
                if (!hit && (op == MD_OP_DIV || op == MD_OP_REM)) begin
                    rc_valid = 1'b1;
                    rc_op = op;
                    rc_mode = m;
                    rc_a = a;
                    rc_b = b;
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/arcino_multdiv_ctrl.md
# arcino_multdiv_ctrl

Sequencer that sits between the ARCINO decode/issue stage and `arcino_multdiv_fast`. It accepts one multiply/divide request at a time over a valid/ready handshake and registers the operands. It drives the datapath enables until the datapath reports ready, then returns the result over a valid/ready response port. It also steers the shared ALU adder to the divider while a division runs, drains safely on pipeline kill, and holds a one-entry result cache for repeated DIV/REM requests.

## Interface
- `RESULT_CACHE`, default 1: enables the one-entry DIV/REM result cache. When 0, every request runs on the datapath.
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `req_valid_i` in 1: request valid.
- `req_ready_o` out 1: request accepted when `req_valid_i && req_ready_o`.
- `req_op_i` in `arcino_defines::md_op_e`: MULL, MULH, DIV or REM.
- `req_signed_mode_i` in 2: bit0 marks A as signed, bit1 marks B as signed.
- `req_op_a_i`, `req_op_b_i` in 32: operands.
- `kill_i` in 1: flush. Aborts the request currently held in the block.
- `resp_valid_o` out 1: response valid.
- `resp_ready_i` in 1: response accepted.
- `resp_result_o` out 32: result.
- `md_mult_en_o`, `md_div_en_o` out 1: datapath enables. At most one is high at a time.
- `md_operator_o` out `md_op_e`, `md_signed_mode_o` out 2, `md_op_a_o`/`md_op_b_o` out 32: registered request fields, held stable for the whole operation.
- `md_ready_i` in 1, `md_result_i` in 32: datapath ready and result.
- `alu_sel_md_o` out 1: ALU adder operand mux select. High means the adder takes the multdiv operands.

## Operation
- States and transitions:
  - IDLE: `req_ready_o`=1. On accept, the request is registered and the block moves to MULT (MULL/MULH), DIV (DIV/REM), or RESP (cache hit).
  - MULT: `md_mult_en_o`=1. When `md_ready_i` is seen, `md_result_i` is captured and the block moves to RESP.
  - DIV: `md_div_en_o`=1 and `alu_sel_md_o`=1. When `md_ready_i` is seen, `md_result_i` is captured, the cache is updated, and the block moves to RESP.
  - DRAIN: the enable of the aborted operation stays high (and `alu_sel_md_o` stays high if it was a divide) until `md_ready_i`. The result is then discarded and the block returns to IDLE. This drain is mandatory because the datapath FSMs only advance while their enable is high.
  - RESP: `resp_valid_o`=1 with the registered result. On `resp_ready_i` the block returns to IDLE.
- `req_ready_o` is high only in IDLE. There is exactly one outstanding request and no bypass.
- Cache:
  - Key: {op, signed_mode, A, B} plus a valid bit.
  - It is written only when a DIV/REM completes without kill.
  - A hit requires an exact key match on a DIV/REM request. A DIV key never matches REM.
  - MUL requests never hit and never invalidate the cache.
- Kill rules:
  - Kill in MULT/DIV: go to DRAIN, no response, no cache update.
  - Kill in RESP: drop the response, go to IDLE.
  - Kill in IDLE together with `req_valid_i`: no accept.
  - Kill in DRAIN: no effect.
  - Kill in the same cycle as `md_ready_i` in MULT/DIV: the result is discarded, no response, and the block goes to IDLE. The datapath has already finished, so no drain is needed.
- Reset: every output is 0 except `req_ready_o`=1. Cache valid is 0 and the state is IDLE. Asserting reset mid-operation resets the datapath too, and no drain is performed.

## Timing
- Cycle 0 is the accept edge. The enable is high from cycle 1.
- Latency to `resp_valid_o` (cycle index):

| Operation | Enable cycles | `resp_valid_o` cycle |
|---|---|---|
| MULL | 3 | 4 |
| MULH | 4 | 5 |
| DIV/REM | 37 (setup 3, compare 31, last, change-sign, finish) | 38 |
| DIV/REM by zero | 2 | 3 |
| Cache hit (no enable) | 0 | 1 |

- `md_result_i` is sampled only in a cycle where the enable is high and `md_ready_i`=1.
- The response and `resp_result_o` hold stable while `resp_ready_i`=0.
- A new request can be accepted in the cycle after the response handshake.

## Test plan
- MULL, A=0x0001_0003, B=0x0002_0005, mode 00 -> `resp_result_o`=0x000B_000F with `resp_valid_o` at cycle 4. `md_mult_en_o` is high for exactly 3 cycles.
- MULH, A=B=0xFFFF_FFFF:
  - mode 11 -> 0x0000_0000 at cycle 5.
  - mode 00 -> 0xFFFF_FFFE.
- Signed division, A=0xFFFF_FFF9 (-7), B=2, mode 11:
  - DIV -> 0xFFFF_FFFD at cycle 38, with `alu_sel_md_o` high for cycles 1-37.
  - REM -> 0xFFFF_FFFF.
- Division by zero, A=5, B=0:
  - DIV -> 0xFFFF_FFFF at cycle 3.
  - REM -> 0x0000_0005 at cycle 3.
- Kill during divide: assert `kill_i` at cycle 10 of a DIV.
  - No response is produced.
  - `md_div_en_o` stays high until `md_ready_i`.
  - `req_ready_o` stays low until the drain completes.
  - A following MULL 3*4 then returns 0x0000_000C at its normal latency.
- Cache and backpressure:
  - Repeat the DIV -7/2 (mode 11) from the signed-division scenario -> `resp_valid_o` at cycle 1, and no `md_div_en_o` is raised.
  - REM with the same operands -> miss, full 38-cycle latency.
  - Hold `resp_ready_i` low for 5 cycles -> `resp_valid_o`/`resp_result_o` stay stable and `req_ready_o` stays low.
